// File: rtl/rv32_pkg.sv
// Shared types for the RV32 data-memory path: MEM-stage request packet,
// EX control packet with load/store widths, and the responder FSM states.
package rv32_pkg;

   // Load width/extension encoding; 3, 6 and 7 are unused and treated as illegal.
   typedef enum logic [2:0] {
      LT_LB  = 3'd0,
      LT_LH  = 3'd1,
      LT_LW  = 3'd2,
      LT_LBU = 3'd4,
      LT_LHU = 3'd5
   } rv32_load_type_t;

   // Store width encoding; 3 is unused and treated as illegal.
   typedef enum logic [1:0] {
      ST_SB = 2'd0,
      ST_SH = 2'd1,
      ST_SW = 2'd2
   } rv32_store_type_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        read_enable;
      logic        write_enable;
      logic        is_load;
      logic        is_store;
   } rv32_mem_packet_t;

   typedef struct packed {
      rv32_load_type_t  load_type;
      rv32_store_type_t store_type;
   } rv32_ex_control_packet_t;

   typedef enum logic {
      DMEM_IDLE = 1'b0,
      DMEM_RESP = 1'b1
   } rv32_dmem_state_t;

   function automatic logic load_type_legal(input rv32_load_type_t lt);
      case (lt)
         LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   function automatic logic store_type_legal(input rv32_store_type_t st);
      case (st)
         ST_SB, ST_SH, ST_SW: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Byte-lane steering for the data memory: builds the store lane mask and the
// replicated write data, and extracts/extends the addressed byte or half of a
// loaded word. Misalignment handling is selected by RV32_DMEM_MISALIGN_TRAP_EN:
// defined -> misaligned halves/words are flagged; undefined -> the offending
// low address bits are dropped (access aligned down) and nothing is flagged.
module rv32_lsu_align
   import rv32_pkg::*;
(
   input  logic [1:0]       offset,
   input  logic             is_store,
   input  rv32_load_type_t  load_type,
   input  rv32_store_type_t store_type,
   input  logic [31:0]      store_data,
   input  logic [31:0]      load_word,
   output logic [31:0]      wr_data,
   output logic [3:0]       wr_mask,
   output logic [31:0]      load_data,
   output logic             misaligned
);

   logic       is_half;
   logic       is_word;
   logic [1:0] eff_off;
   logic [7:0] lane_byte;
   logic [15:0] lane_half;

   // Access size and the aligned-down lane offset actually used.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      is_half = 1'b0;
      is_word = 1'b0;
      if (is_store) begin
         is_half = (store_type == ST_SH);
         is_word = (store_type == ST_SW);
      end else begin
         is_half = (load_type == LT_LH) || (load_type == LT_LHU);
         is_word = (load_type == LT_LW);
      end
      eff_off = offset;
      if (is_half) eff_off[0] = 1'b0;
      if (is_word) eff_off     = 2'b00;
   end

   // Misalignment flag, only raised when trapping is compiled in.
   always_comb begin
`ifdef RV32_DMEM_MISALIGN_TRAP_EN
      misaligned = (is_half && offset[0]) || (is_word && (offset != 2'b00));
`else
      misaligned = 1'b0;
`endif
   end

   // Store lanes: low bits of the source replicated, mask picks the lanes.
   always_comb begin
      wr_data = store_data;
      wr_mask = 4'b0000;
      case (store_type)
         ST_SB: begin
            wr_data = {4{store_data[7:0]}};
            wr_mask = 4'b0001 << eff_off;
         end
         ST_SH: begin
            wr_data = {2{store_data[15:0]}};
            wr_mask = eff_off[1] ? 4'b1100 : 4'b0011;
         end
         ST_SW: begin
            wr_data = store_data;
            wr_mask = 4'b1111;
         end
         default: begin
            wr_data = store_data;
            wr_mask = 4'b0000;
         end
      endcase
   end

   // Load extraction and sign/zero extension.
   always_comb begin
      lane_byte = load_word[{eff_off, 3'b000} +: 8];
      lane_half = eff_off[1] ? load_word[31:16] : load_word[15:0];
      case (load_type)
         LT_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
         LT_LH:   load_data = {{16{lane_half[15]}}, lane_half};
         LT_LW:   load_data = load_word;
         LT_LBU:  load_data = {24'd0, lane_byte};
         LT_LHU:  load_data = {16'd0, lane_half};
         default: load_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Single-cycle data-memory responder for the RV32 MEM stage: valid/ready
// request in, one registered response out per accepted request, full
// throughput when the consumer keeps rsp_ready high. Misaligned accesses trap
// only when RV32_DMEM_MISALIGN_TRAP_EN is defined. DEPTH_WORDS must be a
// power of 2; address bits above the array index are ignored (wrap).
module rv32_dmem_responder
   import rv32_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  rv32_mem_packet_t        req_pkt,
   input  rv32_ex_control_packet_t req_ctrl,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [31:0]             rsp_data,
   output logic                    rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [31:0]      mem [DEPTH_WORDS];
   rv32_dmem_state_t state;
   rv32_dmem_state_t state_next;

   logic             accept;
   logic [IDX_W-1:0] word_idx;
   logic             op_load;
   logic             op_store;
   logic             type_illegal;
   logic             misaligned;
   logic             rsp_err_next;
   logic [31:0]      rsp_data_next;
   logic             do_write;
   logic [31:0]      wr_data;
   logic [3:0]       wr_mask;
   logic [31:0]      load_word;
   logic [31:0]      load_data;
   logic             unused_req_bits;

   assign accept          = req_valid && req_ready;
   assign word_idx        = req_pkt.addr[IDX_W+1:2];
   assign load_word       = mem[word_idx];
   assign unused_req_bits = ^{req_pkt.addr[31:IDX_W+2], req_pkt.is_load, req_pkt.is_store};

   rv32_lsu_align u_align (
      .offset     (req_pkt.addr[1:0]),
      .is_store   (op_store),
      .load_type  (req_ctrl.load_type),
      .store_type (req_ctrl.store_type),
      .store_data (req_pkt.data),
      .load_word  (load_word),
      .wr_data    (wr_data),
      .wr_mask    (wr_mask),
      .load_data  (load_data),
      .misaligned (misaligned)
   );

   // Classify the request and form the response it will produce.
   always_comb begin
      op_load       = req_pkt.read_enable && !req_pkt.write_enable;
      op_store      = req_pkt.write_enable && !req_pkt.read_enable;
      type_illegal  = (op_load  && !load_type_legal(req_ctrl.load_type)) ||
                      (op_store && !store_type_legal(req_ctrl.store_type));
      rsp_err_next  = !(op_load || op_store) || type_illegal || misaligned;
      rsp_data_next = (op_load && !rsp_err_next) ? load_data : 32'd0;
      do_write      = accept && op_store && !rsp_err_next;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state <= DMEM_IDLE;
      else     state <= state_next;
   end

   // FSM next state: a fresh acceptance always (re)enters RESP.
   always_comb begin
      state_next = state;
      case (state)
         DMEM_IDLE: if (accept) state_next = DMEM_RESP;
         DMEM_RESP: begin
            if (accept)         state_next = DMEM_RESP;
            else if (rsp_ready) state_next = DMEM_IDLE;
         end
         default: state_next = DMEM_IDLE;
      endcase
   end

   // FSM outputs: ready when empty or when the held response drains this cycle.
   always_comb begin
      rsp_valid = (state == DMEM_RESP);
      req_ready = (state == DMEM_IDLE) || rsp_ready;
   end

   // Response payload, captured at acceptance and held until replaced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_data <= 32'd0;
         rsp_err  <= 1'b0;
      end else if (accept) begin
         rsp_data <= rsp_data_next;
         rsp_err  <= rsp_err_next;
      end
   end

   // Byte-masked array write at the acceptance edge.
   always_ff @(posedge clk) begin
      // NOTE: the data array is deliberately not reset; contents survive rst and map onto plain RAM.
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed self-checking bench for rv32_dmem_responder (default DEPTH_WORDS).
module tb_rv32_dmem_responder;
   import rv32_pkg::*;

   localparam int DEPTH = 1024;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    req_valid;
   logic                    req_ready;
   rv32_mem_packet_t        req_pkt;
   rv32_ex_control_packet_t req_ctrl;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [31:0]             rsp_data;
   logic                    rsp_err;

   int n_checks = 0;
   int n_errors = 0;

   rv32_dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_pkt   (req_pkt),
      .req_ctrl  (req_ctrl),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input rv32_load_type_t lt,
                        input rv32_store_type_t st);
      req_pkt.addr         = addr;
      req_pkt.data         = data;
      req_pkt.read_enable  = re;
      req_pkt.write_enable = we;
      req_pkt.is_load      = re;
      req_pkt.is_store     = we;
      req_ctrl.load_type   = lt;
      req_ctrl.store_type  = st;
   endtask

   // Present one request at the negedge, accept it at the posedge, then check
   // the response one time unit after that acceptance edge.
   task automatic issue(input string tag, input logic re, input logic we,
                        input logic [31:0] addr, input logic [31:0] data,
                        input rv32_load_type_t lt, input rv32_store_type_t st,
                        input logic [31:0] exp_data, input logic exp_err);
      @(negedge clk);
      drive(re, we, addr, data, lt, st);
      req_valid = 1'b1;
      #1;
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_rsp_data"}, rsp_data, exp_data);
      check({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
   endtask

   task automatic do_load(input string tag, input logic [31:0] addr, input rv32_load_type_t lt,
                          input logic [31:0] exp_data, input logic exp_err);
      issue(tag, 1'b1, 1'b0, addr, 32'd0, lt, ST_SW, exp_data, exp_err);
   endtask

   task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input rv32_store_type_t st, input logic exp_err);
      issue(tag, 1'b0, 1'b1, addr, data, LT_LW, st, 32'd0, exp_err);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, LT_LW, ST_SW);
      #2;
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_rsp_data", rsp_data, 32'd0);
      check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("reset_req_ready", {31'd0, req_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Word store then back-to-back load of the same word (write-first).
      do_store("sw_10", 32'h10, 32'hDEADBEEF, ST_SW, 1'b0);
      do_load("lw_10", 32'h10, LT_LW, 32'hDEADBEEF, 1'b0);

      // Byte store into lane 3 and signed/unsigned readback.
      do_store("sb_13", 32'h13, 32'h00000080, ST_SB, 1'b0);
      do_load("lb_13", 32'h13, LT_LB, 32'hFFFFFF80, 1'b0);
      do_load("lbu_13", 32'h13, LT_LBU, 32'h00000080, 1'b0);
      do_load("lw_10_b", 32'h10, LT_LW, 32'h80ADBEEF, 1'b0);
      do_load("lh_12", 32'h12, LT_LH, 32'hFFFF80AD, 1'b0);
      do_load("lhu_10", 32'h10, LT_LHU, 32'h0000BEEF, 1'b0);

      // Misaligned word load.
`ifdef RV32_DMEM_MISALIGN_TRAP_EN
      do_load("lw_12_mis", 32'h12, LT_LW, 32'h00000000, 1'b1);
`else
      do_load("lw_12_mis", 32'h12, LT_LW, 32'h80ADBEEF, 1'b0);
`endif

      // Illegal requests: no write, error response.
      issue("re_we_both", 1'b1, 1'b1, 32'h10, 32'h0, LT_LW, ST_SW, 32'd0, 1'b1);
      issue("re_we_none", 1'b0, 1'b0, 32'h10, 32'h0, LT_LW, ST_SW, 32'd0, 1'b1);
      do_store("st_type3", 32'h10, 32'h0, rv32_store_type_t'(2'd3), 1'b1);
      do_load("ld_type6", 32'h10, rv32_load_type_t'(3'd6), 32'd0, 1'b1);
      do_load("ld_type3", 32'h10, rv32_load_type_t'(3'd3), 32'd0, 1'b1);
      do_load("lw_10_kept", 32'h10, LT_LW, 32'h80ADBEEF, 1'b0);

      // Half store to upper lanes, byte store with junk in upper data bits.
      do_store("sh_12", 32'h12, 32'hABCD1234, ST_SH, 1'b0);
      do_load("lw_10_sh", 32'h10, LT_LW, 32'h1234BEEF, 1'b0);
      do_store("sb_11", 32'h11, 32'hFFFFFF7F, ST_SB, 1'b0);
      do_load("lw_10_sb", 32'h10, LT_LW, 32'h12347FEF, 1'b0);

      // Address wrap-around.
      do_store("sw_wrap", DEPTH * 4 + 32'h10, 32'hCAFEF00D, ST_SW, 1'b0);
      do_load("lw_wrap", 32'h10, LT_LW, 32'hCAFEF00D, 1'b0);

      // Backpressure: hold rsp_ready low with a pending new request.
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      do_load("bp_lw", 32'h10, LT_LW, 32'hCAFEF00D, 1'b0);
      drive(1'b0, 1'b1, 32'h20, 32'h11112222, LT_LW, ST_SW);
      req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_req_ready", {31'd0, req_ready}, 32'd0);
         check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_rsp_data", rsp_data, 32'hCAFEF00D);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      check("bp_release_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("bp_sw_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_sw_data", rsp_data, 32'd0);
      check("bp_sw_err", {31'd0, rsp_err}, 32'd0);
      do_load("lw_20", 32'h20, LT_LW, 32'h11112222, 1'b0);

      // Asynchronous reset with a response pending.
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      do_load("pre_rst_lw", 32'h10, LT_LW, 32'hCAFEF00D, 1'b0);
      @(negedge clk);
      check("pre_rst_held", {31'd0, rsp_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_idle_valid", {31'd0, rsp_valid}, 32'd0);
      check("post_rst_idle_ready", {31'd0, req_ready}, 32'd1);
      rsp_ready = 1'b1;
      do_load("post_rst_lw", 32'h10, LT_LW, 32'hCAFEF00D, 1'b0);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rv32_dmem_responder.md
RV32_DMEM_RESPONDER -- requirements
Module: rv32_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words in the data array; it must be a power of 2.
REQ-002 SHALL have clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have req_valid, input, 1 bit: the MEM stage presents a request.
REQ-005 SHALL have req_ready, output, 1 bit: the responder accepts the request this cycle.
REQ-006 SHALL have req_pkt, input, rv32_mem_packet_t: addr, data, read_enable, write_enable, is_load, is_store.
REQ-007 SHALL have req_ctrl, input, rv32_ex_control_packet_t: load_type and store_type.
REQ-008 SHALL have rsp_valid, output, 1 bit: a response is pending.
REQ-009 SHALL have rsp_ready, input, 1 bit: the consumer takes the response.
REQ-010 SHALL have rsp_data, output, 32 bits: the load result, already extended; 0 for stores and errors.
REQ-011 SHALL have rsp_err, output, 1 bit: the request was illegal or misaligned.

Function
REQ-012 SHALL use an FSM with two states, IDLE (no response pending) and RESP (response held).
REQ-013 SHALL drive req_ready = (state==IDLE) || rsp_ready, so back-to-back requests run with no bubble.
REQ-014 SHALL accept a request on req_valid && req_ready; state becomes RESP and rsp_valid is high on the next cycle (latency 1).
REQ-015 SHALL leave RESP for IDLE on rsp_valid && rsp_ready when there is no new acceptance in the same cycle; if there is one, state stays RESP with the new response.
REQ-016 SHALL hold rsp_data and rsp_err stable while rsp_valid && !rsp_ready.
REQ-017 SHALL index the array with word index addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap.
REQ-018 SHALL perform stores using store_type 0=SB, 1=SH, 2=SW.
  - Byte lanes are selected by addr[1:0]: SB sets one lane; SH sets lanes {1,0} or {3,2}; SW sets all four.
  - Data is taken from the low bits of req_pkt.data, replicated into the chosen lanes.
  - The write commits at the acceptance edge.
REQ-019 SHALL perform loads using load_type encoding 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
  - The selected byte or half is sign-extended (LB, LH) or zero-extended (LBU, LHU).
REQ-020 SHALL, when read_enable==write_enable (both set or both clear), perform no array access and return rsp_err=1, rsp_data=0.
REQ-021 SHALL treat store_type 3 and load_type 3, 6 or 7 as illegal: rsp_err=1, no write.
REQ-022 SHALL return the newly written value when a load is accepted the cycle after a store to the same word (write-first ordering).
REQ-023 SHALL return rsp_err=0 and rsp_data=0 for a legal store.

Reset
REQ-024 SHALL, while rst is high, force state=IDLE, rsp_valid=0, rsp_data=0 and rsp_err=0 immediately.
REQ-025 SHALL drop any pending response when reset is asserted mid-operation; the array contents are not reset.
REQ-026 SHALL drive req_ready high during reset.

Configuration
REQ-027 SHALL use the macro RV32_DMEM_MISALIGN_TRAP_EN.
  - Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, gives rsp_err=1, rsp_data=0 and no write.
  - Undefined: the offending low address bits are forced to 0 (access aligned down) and rsp_err is never set for misalignment.

Structure
REQ-028 SHALL place the load_type/store_type enums (rv32_load_type_t, rv32_store_type_t) in rv32_pkg; DEPTH_WORDS stays a module parameter.
REQ-029 SHALL implement the byte-lane and extension logic as the sub-module rv32_lsu_align, covering store lane/mask generation and load extraction/extension.

Verification
REQ-030 SHALL cover: SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> rsp_data=0xDEADBEEF, rsp_err=0, one cycle after acceptance.
REQ-031 SHALL cover: SB addr=0x13 data=0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-032 SHALL cover: rsp_ready held low 3 cycles with rsp_valid high -> req_ready=0 and rsp_data stable; when rsp_ready rises with a new req_valid -> accepted in the same cycle, no bubble.
REQ-033 SHALL cover: LW addr=0x12 -> with the macro, rsp_err=1, rsp_data=0; without it, returns the word at 0x10.
REQ-034 SHALL cover: read_enable=write_enable=1 -> rsp_err=1, array unchanged; rst pulsed with rsp_valid high -> rsp_valid=0 asynchronously and state=IDLE.
REQ-035 SHALL cover: SW to addr DEPTH_WORDS*4+0x10 -> a later LW 0x10 returns that data (wrap-around).
